// File: rtl/regfile_access_arbiter.sv
// Purpose: round-robin arbiter giving two requesters (m0 core, m1 debug/load) access to one register-file port.
// Latency: handshake edge T, register-file access in cycle T+1, response pulse in cycle T+2.
// Backpressure: ready is given only in IDLE; requests arriving while busy wait with valid held (no buffering).
module regfile_access_arbiter #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_valid,
   output logic              m0_ready,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_valid,
   output logic              m1_ready,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [ADDR_W-1:0] rf_addr,
   output logic              rf_we,
   output logic [DATA_W-1:0] rf_wdata,
   input  logic [DATA_W-1:0] rf_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t              state_q, state_d;
   logic                last_grant_q, last_grant_d;
   logic                id_q, id_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
   logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;

   logic                gnt0, gnt1;
   logic                zero_hit;
   logic [DATA_W-1:0]   rdata_cap;

   // Index 0 is treated as hardwired zero only when ZERO_REG is enabled.
   assign zero_hit = (ZERO_REG != 0) && (addr_q == '0);

   // Winner selection: a lone requester wins; on a tie the one not granted last time wins.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (state_q == IDLE && !rst) begin
         if (m0_valid && (!m1_valid || last_grant_q)) begin
            gnt0 = 1'b1;
         end else if (m1_valid) begin
            gnt1 = 1'b1;
         end
      end
   end

   // Value returned to the requester: real read data, or zero for writes and hardwired index 0.
   always_comb begin
      rdata_cap = rf_rdata;
      if (we_q || zero_hit) begin
         rdata_cap = '0;
      end
   end

   // Next-state logic: latch the winning request, access the file, then pulse the response.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      id_d         = id_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      m0_rdata_d   = m0_rdata_q;
      m1_rdata_d   = m1_rdata_q;
      case (state_q)
         IDLE: begin
            if (gnt0) begin
               state_d      = ISSUE;
               last_grant_d = 1'b0;
               id_d         = 1'b0;
               we_d         = m0_we;
               addr_d       = m0_addr;
               wdata_d      = m0_wdata;
            end else if (gnt1) begin
               state_d      = ISSUE;
               last_grant_d = 1'b1;
               id_d         = 1'b1;
               we_d         = m1_we;
               addr_d       = m1_addr;
               wdata_d      = m1_wdata;
            end
         end
         ISSUE: begin
            state_d = RESP;
            if (id_q) begin
               m1_rdata_d = rdata_cap;
            end else begin
               m0_rdata_d = rdata_cap;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and latched-request registers; synchronous reset aborts any transaction in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         id_q         <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         m0_rdata_q   <= '0;
         m1_rdata_q   <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         id_q         <= id_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         m0_rdata_q   <= m0_rdata_d;
         m1_rdata_q   <= m1_rdata_d;
      end
   end

   assign m0_ready  = gnt0;
   assign m1_ready  = gnt1;
   assign rf_addr   = addr_q;
   assign rf_wdata  = wdata_q;
   assign rf_we     = (state_q == ISSUE) && we_q && !zero_hit && !rst;
   assign m0_rvalid = (state_q == RESP) && !id_q && !rst;
   assign m1_rvalid = (state_q == RESP) && id_q && !rst;
   assign m0_rdata  = m0_rdata_q;
   assign m1_rdata  = m1_rdata_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Bench for regfile_access_arbiter: directed scenarios followed by random traffic from both requesters.
// A transaction-level model predicts grants, register-file writes and responses; a negedge monitor checks them.
// Requests are driven by blocking tasks that hold valid until accepted, with a bounded wait.
module tb_regfile_access_arbiter;

   logic        clk;
   logic        rst;
   logic        m0_valid, m0_ready, m0_we, m0_rvalid;
   logic [4:0]  m0_addr;
   logic [31:0] m0_wdata, m0_rdata;
   logic        m1_valid, m1_ready, m1_we, m1_rvalid;
   logic [4:0]  m1_addr;
   logic [31:0] m1_wdata, m1_rdata;
   logic [4:0]  rf_addr;
   logic        rf_we;
   logic [31:0] rf_wdata, rf_rdata;
   logic        busy;

   regfile_access_arbiter #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
      .clk(clk), .rst(rst),
      .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_we(m0_we), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_we(m1_we), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .rf_addr(rf_addr), .rf_we(rf_we), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file seen by the DUT, and the model's idea of its contents.
   logic [31:0] rf_mem  [32];
   logic [31:0] ref_mem [32];
   assign rf_rdata = rf_mem[rf_addr];
   always @(posedge clk) if (rf_we) rf_mem[rf_addr] <= rf_wdata;

   typedef struct {
      int          id;
      bit          we;
      logic [4:0]  addr;
      int          cyc;
   } txn_t;

   txn_t        sb[$];
   int          glog[$];
   int          gcyc[$];
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          busy_left = 0;
   int          ref_last = 1;
   bit          pend_vld = 0;
   bit          pend_we;
   logic [4:0]  pend_addr;
   logic [31:0] pend_wdata;
   int          pend_cyc;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor and reference model, evaluated mid-cycle.
   always @(negedge clk) begin
      int          winner;
      txn_t        t;
      logic [31:0] e;
      logic [31:0] act_rd;
      bit          exp_we;
      if (rst) begin
         chk("rst_ready", 32'({m1_ready, m0_ready}), 32'd0);
         chk("rst_rf_we", 32'(rf_we), 32'd0);
         chk("rst_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'd0);
         sb.delete();
         busy_left = 0;
         ref_last  = 1;
         pend_vld  = 0;
      end else begin
         // Register-file write in the cycle after acceptance, suppressed for index 0.
         if (pend_vld && pend_cyc == cyc - 1) begin
            exp_we = pend_we && (pend_addr != 5'd0);
            chk("rf_we_issue", 32'(rf_we), 32'(exp_we));
            chk("rf_addr_issue", 32'(rf_addr), 32'(pend_addr));
            if (exp_we) begin
               chk("rf_wdata_issue", rf_wdata, pend_wdata);
               ref_mem[pend_addr] = pend_wdata;
            end
            pend_vld = 0;
         end else begin
            chk("rf_we_idle", 32'(rf_we), 32'd0);
         end
         // Responses, two cycles after acceptance, in order.
         if (m0_rvalid || m1_rvalid) begin
            if (sb.size() == 0) begin
               chk("rvalid_unexpected", 32'({m1_rvalid, m0_rvalid}), 32'd0);
            end else begin
               t = sb.pop_front();
               chk("rvalid_id", 32'({m1_rvalid, m0_rvalid}), (t.id == 1) ? 32'd2 : 32'd1);
               chk("rvalid_latency", 32'(cyc - t.cyc), 32'd2);
               e = (t.we || t.addr == 5'd0) ? 32'd0 : ref_mem[t.addr];
               act_rd = (t.id == 1) ? m1_rdata : m0_rdata;
               chk("rdata", act_rd, e);
            end
         end else if (sb.size() > 0 && cyc - sb[0].cyc >= 2) begin
            chk("rvalid_missing", 32'd0, 32'd1);
            void'(sb.pop_front());
         end
         // Grant prediction: one transaction at a time, lone requester wins, ties alternate.
         winner = -1;
         if (busy_left == 0) begin
            if (m0_valid && m1_valid) winner = 1 - ref_last;
            else if (m0_valid)        winner = 0;
            else if (m1_valid)        winner = 1;
         end
         chk("ready", 32'({m1_ready, m0_ready}), (winner == 1) ? 32'd2 : (winner == 0) ? 32'd1 : 32'd0);
         chk("busy", 32'(busy), 32'(busy_left != 0));
         if (winner >= 0) begin
            t.id   = winner;
            t.we   = (winner == 1) ? m1_we : m0_we;
            t.addr = (winner == 1) ? m1_addr : m0_addr;
            t.cyc  = cyc;
            sb.push_back(t);
            glog.push_back(winner);
            gcyc.push_back(cyc);
            pend_vld   = 1;
            pend_we    = t.we;
            pend_addr  = t.addr;
            pend_wdata = (winner == 1) ? m1_wdata : m0_wdata;
            pend_cyc   = cyc;
            ref_last   = winner;
            busy_left  = 2;
         end else if (busy_left > 0) begin
            busy_left--;
         end
      end
   end

   // Raise valid with a payload, hold it until accepted, then drop it just after the edge.
   task automatic req(input int id, input bit we, input logic [4:0] a, input logic [31:0] d);
      bit ok = 0;
      if (id == 0) begin
         m0_valid = 1'b1; m0_we = we; m0_addr = a; m0_wdata = d;
      end else begin
         m1_valid = 1'b1; m1_we = we; m1_addr = a; m1_wdata = d;
      end
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         ok = (id == 0) ? (m0_valid && m0_ready) : (m1_valid && m1_ready);
      end
      @(posedge clk);
      #1;
      if (id == 0) m0_valid = 1'b0;
      else         m1_valid = 1'b0;
      if (!ok) chk("handshake_timeout", 32'd0, 32'd1);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] saved7;
      for (int i = 0; i < 32; i++) begin
         ref_mem[i] = $urandom;
         rf_mem[i] <= ref_mem[i];
      end
      rf_mem[0] <= 32'hFFFF_FFFF;
      rst = 1'b1;
      m0_valid = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
      m1_valid = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
      idle(3);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_rf_addr", 32'(rf_addr), 32'd0);
      chk("reset_rf_wdata", rf_wdata, 32'd0);
      chk("reset_m0_rdata", m0_rdata, 32'd0);
      chk("reset_m1_rdata", m1_rdata, 32'd0);
      @(posedge clk);
      #1;

      // Write then read back of the same index, from different requesters.
      req(0, 1'b1, 5'd5, 32'hDEAD_BEEF);
      req(1, 1'b0, 5'd5, 32'd0);
      idle(4);

      // Both requesters continuously valid: strict alternation, three cycles apart.
      glog.delete();
      gcyc.delete();
      fork
         begin
            req(0, 1'b1, 5'd9, 32'h1111_0000);
            req(0, 1'b0, 5'd10, 32'd0);
         end
         begin
            req(1, 1'b1, 5'd10, 32'h2222_0000);
            req(1, 1'b0, 5'd9, 32'd0);
         end
      join
      chk("tie_count", 32'(glog.size()), 32'd4);
      if (glog.size() == 4) begin
         for (int i = 0; i < 4; i++) chk("tie_order", 32'(glog[i]), 32'(i % 2));
         for (int i = 1; i < 4; i++) chk("tie_spacing", 32'(gcyc[i] - gcyc[i-1]), 32'd3);
      end
      idle(4);

      // Hardwired index 0: write suppressed, read returns zero despite the file holding ones.
      req(0, 1'b1, 5'd0, 32'h1234_5678);
      req(1, 1'b0, 5'd0, 32'd0);
      idle(4);

      // Reset during the access cycle of a write to index 7: no write, no response.
      saved7 = rf_mem[7];
      req(0, 1'b1, 5'd7, 32'h7777_7777);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      idle(3);
      chk("aborted_write", rf_mem[7], saved7);
      glog.delete();
      fork
         req(0, 1'b0, 5'd7, 32'd0);
         req(1, 1'b0, 5'd7, 32'd0);
      join
      chk("post_reset_first_grant", (glog.size() > 0) ? 32'(glog[0]) : 32'hFFFF_FFFF, 32'd0);
      idle(4);

      // Back-to-back write then read of index 3.
      req(0, 1'b1, 5'd3, 32'hA5A5_A5A5);
      req(1, 1'b0, 5'd3, 32'd0);
      idle(4);

      // Random traffic from both sides with random gaps.
      fork
         for (int k = 0; k < 40; k++) begin
            idle($urandom_range(0, 2));
            req(0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
         end
         for (int k = 0; k < 40; k++) begin
            idle($urandom_range(0, 2));
            req(1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
         end
      join

      idle(6);
      @(negedge clk);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/regfile_access_arbiter.md
Name: regfile_access_arbiter

Overview:
Arbitrates a single register-file access port between two requesters: m0, the multicycle core datapath, and m1, the debug/load unit. The block sequences each transaction through the register file and returns read data, or a write acknowledge, to the requester that issued it. It sits between the requesters and the register-file slices, driving their shared address, write-enable and write-data lines. One transaction is in flight at a time, and requesters are served round-robin.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register index width
ZERO_REG, 1, when 1 register index 0 is hardwired: writes to it are suppressed and reads of it return 0

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-high
m0_valid  input  1  requester 0 has a request
m0_ready  output  1  requester 0 request accepted this cycle
m0_we  input  1  1 = write, 0 = read
m0_addr  input  ADDR_W  register index
m0_wdata  input  DATA_W  write data
m0_rvalid  output  1  one-cycle response pulse for requester 0
m0_rdata  output  DATA_W  read data; 0 for writes
m1_valid, m1_ready, m1_we, m1_addr, m1_wdata, m1_rvalid, m1_rdata  same as m0_*, for requester 1
rf_addr  output  ADDR_W  register-file index
rf_we  output  1  register-file write enable
rf_wdata  output  DATA_W  register-file write data
rf_rdata  input  DATA_W  register-file read data, combinational from rf_addr
busy  output  1  high whenever state != IDLE

Behaviour:
- FSM states: IDLE, ISSUE, RESP.
- Transitions: IDLE -> ISSUE on a handshake; ISSUE -> RESP unconditionally; RESP -> IDLE unconditionally.
- Throughput is at most one transaction per 3 cycles.
- IDLE, winner selection:
  - Only m0 valid: m0 wins. Only m1 valid: m1 wins.
  - Both valid: the requester other than last_grant wins.
  - mX_ready is combinational and high only for the winner, only in IDLE.
- Handshake is mX_valid & mX_ready. On the handshake edge:
  - latch we, addr, wdata and requester id;
  - set last_grant = id;
  - go to ISSUE.
- ISSUE:
  - rf_addr = latched addr; rf_wdata = latched wdata.
  - rf_we = latched we & !(ZERO_REG & addr == 0).
  - At the end of ISSUE, capture rdata_q:
    - read of index 0 with ZERO_REG=1: capture 0;
    - other reads: capture rf_rdata;
    - writes: capture 0.
- RESP: m[id]_rvalid = 1 for exactly one cycle; m[id]_rdata = rdata_q.
- Latency: handshake edge T, register-file access in cycle T+1, rvalid in cycle T+2.
- Outside ISSUE:
  - rf_we = 0; rf_addr and rf_wdata hold their last values.
  - mX_rdata holds its last value but is meaningful only while its rvalid is high.
  - Each rvalid is 0 outside RESP.
- Requests arriving while busy wait. valid must stay high with stable payload until ready; the block does not buffer requests.
- A read of the index written by the previous transaction returns the new value, because the write completed in ISSUE before this read's ISSUE.
- Reset:
  - After a reset edge: state = IDLE; last_grant = 1, so m0 wins the first tie.
  - rdata_q and all latched fields = 0.
  - All ready, rvalid, rf_we and busy outputs = 0.
  - While rst is high, mX_ready and rf_we are forced to 0 combinationally.
- Reset mid-transaction aborts it: no rvalid is issued, and a write in ISSUE during the reset cycle is not performed.
- Both valid in the cycle after a grant: no grant is issued until IDLE; the alternation then follows last_grant.

Test Plan:
- Reset, then m0 write addr=5, wdata=0xDEADBEEF -> m0_ready in cycle 0; rf_we=1, rf_addr=5 in cycle 1; m0_rvalid=1, m0_rdata=0 in cycle 2; busy high in cycles 1-2.
- m1 read addr=5 with rf_rdata modelled as 0xDEADBEEF -> m1_rvalid in cycle 2 after the handshake, m1_rdata=0xDEADBEEF; m0_rvalid stays 0.
- m0 and m1 both valid continuously for 4 transactions -> grant order m0, m1, m0, m1; handshakes exactly 3 cycles apart.
- ZERO_REG=1: write addr=0, data=0x12345678 -> rf_we stays 0 throughout. Read addr=0 with rf_rdata driven 0xFFFFFFFF -> rdata=0.
- rst asserted during ISSUE of a write to addr=7 -> rf_we=0 in that cycle, no rvalid follows. After reset, with both requesters valid, m0 is granted first.
- Back-to-back write of addr=3 with 0xA5A5A5A5 by m0, then read of addr=3 by m1, register file modelled -> m1_rdata=0xA5A5A5A5.
